// File: rtl/solitaire_pkg.sv
// solitaire_pkg: shared types and geometry helpers for the peg solitaire blocks.
//   dir_t          move / cursor direction encoding (LEFT=00, RIGHT=01, UP=10, DOWN=11)
//   state_t        move controller FSM states
//   space_exists   true when a signed (x,y) lies on the 33-space cross-shaped board
//   dir_dx/dir_dy  unit step in x/y for a direction
package solitaire_pkg;

    localparam logic signed [3:0] BOARD_WIDTH = 4'sd7;
    localparam logic signed [3:0] MIN_VAL     = 4'sd2;
    localparam logic signed [3:0] MAX_VAL     = 4'sd4;
    localparam logic [2:0]        CENTRE      = 3'd3;

    typedef enum logic [1:0] {
        DIR_LEFT  = 2'b00,
        DIR_RIGHT = 2'b01,
        DIR_UP    = 2'b10,
        DIR_DOWN  = 2'b11
    } dir_t;

    typedef enum logic [1:0] {
        ST_NAVIGATE = 2'b00,
        ST_ARMED    = 2'b01,
        ST_ISSUE    = 2'b10,
        ST_REJECT   = 2'b11
    } state_t;

    // Signed inputs so that a step below zero is seen as off-board instead of wrapping.
    function automatic logic space_exists(input logic signed [3:0] x,
                                          input logic signed [3:0] y);
        logic on_grid;
        logic vert_bar;
        logic horiz_bar;
        on_grid   = (x >= 4'sd0) && (x < BOARD_WIDTH) && (y >= 4'sd0) && (y < BOARD_WIDTH);
        vert_bar  = (x >= MIN_VAL) && (x <= MAX_VAL);
        horiz_bar = (y >= MIN_VAL) && (y <= MAX_VAL);
        return on_grid && (vert_bar || horiz_bar);
    endfunction

    function automatic logic signed [3:0] dir_dx(input dir_t d);
        case (d)
            DIR_LEFT:  return -4'sd1;
            DIR_RIGHT: return 4'sd1;
            default:   return 4'sd0;
        endcase
    endfunction

    function automatic logic signed [3:0] dir_dy(input dir_t d);
        case (d)
            DIR_UP:   return -4'sd1;
            DIR_DOWN: return 4'sd1;
            default:  return 4'sd0;
        endcase
    endfunction

endpackage

// File: rtl/solitaire_debounce.sv
// solitaire_debounce: 2-FF synchronizer, debounce counter and press pulse for one button.
//   clk    system clock
//   rst    synchronous active-high reset
//   raw    asynchronous active-high button
//   press  one-cycle pulse, registered one cycle after the debounced level rises
module solitaire_debounce #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic press
);

    logic        sync_meta;
    logic        sync_out;
    logic        level;
    logic        level_prev;
    logic [15:0] stable_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_meta  <= 1'b0;
            sync_out   <= 1'b0;
            level      <= 1'b0;
            level_prev <= 1'b0;
            stable_cnt <= '0;
            press      <= 1'b0;
        end else begin
            sync_meta  <= raw;
            sync_out   <= sync_meta;
            level_prev <= level;
            press      <= level & ~level_prev;
            // Count consecutive disagreeing cycles; the last one of the run flips the level.
            if (sync_out == level) begin
                stable_cnt <= '0;
            end else if (stable_cnt == DEBOUNCE_CYCLES - 16'd1) begin
                level      <= sync_out;
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + 16'd1;
            end
        end
    end

endmodule

// File: rtl/solitaire_move_ctrl.sv
// solitaire_move_ctrl: button front end for the peg solitaire board.
//   clk, rst                       system clock, synchronous active-high reset
//   btn_up/down/left/right/sel     raw asynchronous buttons
//   cursor_x, cursor_y             current cursor space
//   armed                          high while a move is being armed
//   piece_x, piece_y, direction    source space and direction of the last issued move
//   move_valid                     one-cycle strobe for an issued move
//   move_reject                    one-cycle strobe for a jump that would land off the board
//
// state    | meaning
// NAVIGATE | direction presses move the cursor, sel arms
// ARMED    | waiting for the jump direction; sel or idle timeout cancels
// ISSUE    | move_valid strobe, cursor already on the landing space
// REJECT   | move_reject strobe, cursor unchanged
module solitaire_move_ctrl
    import solitaire_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter logic [23:0] ARM_TIMEOUT     = 24'd10000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_sel,
    output logic [2:0] cursor_x,
    output logic [2:0] cursor_y,
    output logic       armed,
    output logic [2:0] piece_x,
    output logic [2:0] piece_y,
    output logic [1:0] direction,
    output logic       move_valid,
    output logic       move_reject
);

    // Bit order is the arbitration priority, highest first: sel, up, down, left, right.
    logic [4:0] raw_btn;
    logic [4:0] press;

    assign raw_btn = {btn_sel, btn_up, btn_down, btn_left, btn_right};

    for (genvar i = 0; i < 5; i++) begin : g_btn
        solitaire_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk  (clk),
            .rst  (rst),
            .raw  (raw_btn[i]),
            .press(press[i])
        );
    end

    state_t            state_q, state_d;
    dir_t              dir_q;
    logic [23:0]       timer_q;
    logic              press_sel;
    logic              press_dir;
    dir_t              press_d;
    logic signed [3:0] cur_x, cur_y;
    logic signed [3:0] step1_x, step1_y, step2_x, step2_y;
    logic [2:0]        cursor_x_d, cursor_y_d;
    logic              load_move;

    always_comb begin
        press_sel = press[4];
        press_dir = 1'b0;
        press_d   = DIR_LEFT;
        if (!press[4]) begin
            if (press[3]) begin
                press_dir = 1'b1;
                press_d   = DIR_UP;
            end else if (press[2]) begin
                press_dir = 1'b1;
                press_d   = DIR_DOWN;
            end else if (press[1]) begin
                press_dir = 1'b1;
                press_d   = DIR_LEFT;
            end else if (press[0]) begin
                press_dir = 1'b1;
                press_d   = DIR_RIGHT;
            end
        end
    end

    assign cur_x   = signed'({1'b0, cursor_x});
    assign cur_y   = signed'({1'b0, cursor_y});
    assign step1_x = cur_x + dir_dx(press_d);
    assign step1_y = cur_y + dir_dy(press_d);
    assign step2_x = step1_x + dir_dx(press_d);
    assign step2_y = step1_y + dir_dy(press_d);

    always_comb begin
        state_d    = state_q;
        cursor_x_d = cursor_x;
        cursor_y_d = cursor_y;
        load_move  = 1'b0;
        case (state_q)
            ST_NAVIGATE: begin
                if (press_sel) begin
                    state_d = ST_ARMED;
                end else if (press_dir && space_exists(step1_x, step1_y)) begin
                    cursor_x_d = step1_x[2:0];
                    cursor_y_d = step1_y[2:0];
                end
            end
            ST_ARMED: begin
                if (press_sel) begin
                    state_d = ST_NAVIGATE;
                end else if (press_dir) begin
                    if (space_exists(step2_x, step2_y)) begin
                        state_d    = ST_ISSUE;
                        load_move  = 1'b1;
                        cursor_x_d = step2_x[2:0];
                        cursor_y_d = step2_y[2:0];
                    end else begin
                        state_d = ST_REJECT;
                    end
                end else if (timer_q == '0) begin
                    state_d = ST_NAVIGATE;
                end
            end
            default: state_d = ST_NAVIGATE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_NAVIGATE;
            cursor_x <= CENTRE;
            cursor_y <= CENTRE;
            piece_x  <= CENTRE;
            piece_y  <= CENTRE;
            dir_q    <= DIR_LEFT;
            timer_q  <= '0;
        end else begin
            state_q  <= state_d;
            cursor_x <= cursor_x_d;
            cursor_y <= cursor_y_d;
            if (load_move) begin
                piece_x <= cursor_x;
                piece_y <= cursor_y;
                dir_q   <= press_d;
            end
            // Loaded so the terminal count is reached after exactly ARM_TIMEOUT idle cycles.
            if (state_q != ST_ARMED && state_d == ST_ARMED) begin
                timer_q <= ARM_TIMEOUT - 24'd1;
            end else if (state_q == ST_ARMED && timer_q != '0) begin
                timer_q <= timer_q - 24'd1;
            end
        end
    end

    assign armed       = (state_q == ST_ARMED);
    assign move_valid  = (state_q == ST_ISSUE);
    assign move_reject = (state_q == ST_REJECT);
    assign direction   = dir_q;

endmodule

// File: tb/tb_solitaire_move_ctrl.sv
// tb_solitaire_move_ctrl: self-checking bench for solitaire_move_ctrl with
// DEBOUNCE_CYCLES=4 and ARM_TIMEOUT=100. Expected strobes are queued before the
// stimulus that causes them and consumed by a monitor when the DUT strobes.
module tb_solitaire_move_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0, btn_sel = 1'b0;
    logic [2:0] cursor_x, cursor_y, piece_x, piece_y;
    logic [1:0] direction;
    logic       armed, move_valid, move_reject;

    int n_cmp  = 0;
    int n_fail = 0;

    localparam int B_UP = 0, B_DOWN = 1, B_LEFT = 2, B_RIGHT = 3, B_SEL = 4;

    typedef struct {
        bit         is_reject;
        logic [2:0] x;
        logic [2:0] y;
        logic [1:0] dir;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    solitaire_move_ctrl #(
        .DEBOUNCE_CYCLES(16'd4),
        .ARM_TIMEOUT    (24'd100)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .btn_sel    (btn_sel),
        .cursor_x   (cursor_x),
        .cursor_y   (cursor_y),
        .armed      (armed),
        .piece_x    (piece_x),
        .piece_y    (piece_y),
        .direction  (direction),
        .move_valid (move_valid),
        .move_reject(move_reject)
    );

    always #5 clk = ~clk;

    // Strobe monitor: every strobe cycle must match the head of the scoreboard.
    always @(negedge clk) begin
        if (move_valid === 1'b1 && move_reject === 1'b1) begin
            n_cmp++;
            n_fail++;
            $display("FAIL strobe_overlap: valid=%b reject=%b, required not both high", move_valid, move_reject);
        end else if (move_valid === 1'b1 || move_reject === 1'b1) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_strobe: valid=%b reject=%b, required no strobe", move_valid, move_reject);
            end else begin
                mon_e = sb.pop_front();
                if (mon_e.is_reject) begin
                    if (move_reject !== 1'b1) begin
                        n_fail++;
                        $display("FAIL reject_strobe: valid=%b reject=%b, required reject", move_valid, move_reject);
                    end
                end else if (move_valid !== 1'b1 || piece_x !== mon_e.x || piece_y !== mon_e.y
                             || direction !== mon_e.dir) begin
                    n_fail++;
                    $display("FAIL move_strobe: valid=%b piece=(%0d,%0d) dir=%b, required valid piece=(%0d,%0d) dir=%b",
                             move_valid, piece_x, piece_y, direction, mon_e.x, mon_e.y, mon_e.dir);
                end
            end
        end
    end

    task automatic set_btn(input int b, input logic v);
        case (b)
            B_UP:    btn_up    = v;
            B_DOWN:  btn_down  = v;
            B_LEFT:  btn_left  = v;
            B_RIGHT: btn_right = v;
            default: btn_sel   = v;
        endcase
    endtask

    // Clean press: held long enough to debounce, released long enough to re-arm.
    task automatic press(input int b);
        set_btn(b, 1'b1);
        repeat (10) @(posedge clk);
        #1 set_btn(b, 1'b0);
        repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        {btn_up, btn_down, btn_left, btn_right, btn_sel} = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        n_cmp++;
        if ({cursor_x, cursor_y} !== {3'd3, 3'd3}) begin
            n_fail++;
            $display("FAIL reset_cursor: got (%0d,%0d), required (3,3)", cursor_x, cursor_y);
        end
        n_cmp++;
        if ({piece_x, piece_y, direction} !== {3'd3, 3'd3, 2'b00}) begin
            n_fail++;
            $display("FAIL reset_piece: got (%0d,%0d) dir=%b, required (3,3) dir=00", piece_x, piece_y, direction);
        end
        n_cmp++;
        if ({armed, move_valid, move_reject} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags: got armed/valid/reject=%b, required 000", {armed, move_valid, move_reject});
        end
    endtask

    task automatic test_debounce();
        apply_reset();
        @(posedge clk);
        #1 btn_right = 1'b1;
        repeat (3) @(posedge clk);
        #1 btn_right = 1'b0;
        repeat (15) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (cursor_x !== 3'd3) begin
            n_fail++;
            $display("FAIL glitch_reject: cursor_x=%0d, required 3", cursor_x);
        end
        // Pulse is high after the 7th sampling edge; the cursor takes it on the 8th.
        @(posedge clk);
        #1 btn_right = 1'b1;
        repeat (7) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (cursor_x !== 3'd3) begin
            n_fail++;
            $display("FAIL press_latency_early: cursor_x=%0d, required 3", cursor_x);
        end
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (cursor_x !== 3'd4) begin
            n_fail++;
            $display("FAIL press_latency: cursor_x=%0d, required 4", cursor_x);
        end
        repeat (2) @(posedge clk);
        #1 btn_right = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({cursor_x, cursor_y} !== {3'd4, 3'd3}) begin
            n_fail++;
            $display("FAIL hold_single_step: got (%0d,%0d), required (4,3)", cursor_x, cursor_y);
        end
    endtask

    task automatic test_cursor_bounds();
        int exp_y;
        apply_reset();
        for (int i = 1; i <= 4; i++) begin
            press(B_UP);
            exp_y = (3 - i < 0) ? 0 : 3 - i;
            n_cmp++;
            if ({cursor_x, cursor_y} !== {3'd3, 3'(exp_y)}) begin
                n_fail++;
                $display("FAIL cursor_up_%0d: got (%0d,%0d), required (3,%0d)", i, cursor_x, cursor_y, exp_y);
            end
        end
        for (int i = 1; i <= 2; i++) begin
            press(B_LEFT);
            n_cmp++;
            if ({cursor_x, cursor_y} !== {3'd2, 3'd0}) begin
                n_fail++;
                $display("FAIL cursor_left_%0d: got (%0d,%0d), required (2,0)", i, cursor_x, cursor_y);
            end
        end
    endtask

    task automatic test_legal_move();
        apply_reset();
        press(B_DOWN);
        press(B_DOWN);
        press(B_SEL);
        n_cmp++;
        if (armed !== 1'b1) begin
            n_fail++;
            $display("FAIL legal_armed: armed=%b, required 1", armed);
        end
        sb.push_back('{is_reject: 1'b0, x: 3'd3, y: 3'd5, dir: 2'b10});
        press(B_UP);
        n_cmp++;
        if ({cursor_x, cursor_y, armed} !== {3'd3, 3'd3, 1'b0}) begin
            n_fail++;
            $display("FAIL legal_after: cursor=(%0d,%0d) armed=%b, required (3,3) armed=0", cursor_x, cursor_y, armed);
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL legal_strobe_seen: pending=%0d, required 0", sb.size());
        end
    endtask

    task automatic test_reject();
        apply_reset();
        repeat (3) press(B_UP);
        press(B_LEFT);
        press(B_SEL);
        sb.push_back('{is_reject: 1'b1, x: 3'd0, y: 3'd0, dir: 2'b00});
        press(B_LEFT);
        n_cmp++;
        if ({cursor_x, cursor_y, armed} !== {3'd2, 3'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reject_after: cursor=(%0d,%0d) armed=%b, required (2,0) armed=0", cursor_x, cursor_y, armed);
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL reject_strobe_seen: pending=%0d, required 0", sb.size());
        end
    endtask

    task automatic test_cancel_timeout();
        apply_reset();
        press(B_SEL);
        press(B_SEL);
        n_cmp++;
        if (armed !== 1'b0) begin
            n_fail++;
            $display("FAIL cancel: armed=%b, required 0", armed);
        end
        // ARMED is entered on the 8th edge after the raw press.
        @(posedge clk);
        #1 btn_sel = 1'b1;
        repeat (8) @(posedge clk);
        @(negedge clk);
        btn_sel = 1'b0;
        n_cmp++;
        if (armed !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_enter: armed=%b, required 1", armed);
        end
        repeat (99) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (armed !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_early: armed=%b after 99 idle cycles, required 1", armed);
        end
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({armed, cursor_x, cursor_y} !== {1'b0, 3'd3, 3'd3}) begin
            n_fail++;
            $display("FAIL timeout_cancel: armed=%b cursor=(%0d,%0d), required armed=0 (3,3)", armed, cursor_x, cursor_y);
        end
    endtask

    task automatic test_reset_in_issue();
        apply_reset();
        press(B_RIGHT);
        press(B_SEL);
        sb.push_back('{is_reject: 1'b0, x: 3'd4, y: 3'd3, dir: 2'b10});
        @(posedge clk);
        #1 btn_up = 1'b1;
        repeat (8) @(posedge clk);
        #1 rst = 1'b1;
        btn_up = 1'b0;
        n_cmp++;
        if (move_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL issue_before_reset: move_valid=%b, required 1", move_valid);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({cursor_x, cursor_y, piece_x, piece_y, direction} !== {3'd3, 3'd3, 3'd3, 3'd3, 2'b00}) begin
            n_fail++;
            $display("FAIL reset_in_issue_regs: cursor=(%0d,%0d) piece=(%0d,%0d) dir=%b, required (3,3) (3,3) 00",
                     cursor_x, cursor_y, piece_x, piece_y, direction);
        end
        n_cmp++;
        if ({armed, move_valid, move_reject} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_in_issue_flags: armed/valid/reject=%b, required 000", {armed, move_valid, move_reject});
        end
        repeat (12) @(posedge clk);
        #1;
    endtask

    task automatic test_simultaneous();
        apply_reset();
        @(posedge clk);
        #1 btn_sel = 1'b1;
        btn_right = 1'b1;
        repeat (10) @(posedge clk);
        #1 btn_sel = 1'b0;
        btn_right = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({armed, cursor_x, cursor_y} !== {1'b1, 3'd3, 3'd3}) begin
            n_fail++;
            $display("FAIL simultaneous: armed=%b cursor=(%0d,%0d), required armed=1 (3,3)", armed, cursor_x, cursor_y);
        end
        press(B_SEL);
    endtask

    task automatic test_back_to_back();
        apply_reset();
        press(B_SEL);
        sb.push_back('{is_reject: 1'b0, x: 3'd3, y: 3'd3, dir: 2'b01});
        press(B_RIGHT);
        n_cmp++;
        if ({cursor_x, cursor_y} !== {3'd5, 3'd3}) begin
            n_fail++;
            $display("FAIL b2b_landing: cursor=(%0d,%0d), required (5,3)", cursor_x, cursor_y);
        end
        press(B_SEL);
        sb.push_back('{is_reject: 1'b1, x: 3'd0, y: 3'd0, dir: 2'b00});
        press(B_DOWN);
        n_cmp++;
        if ({cursor_x, cursor_y, piece_x, piece_y, direction} !== {3'd5, 3'd3, 3'd3, 3'd3, 2'b01}) begin
            n_fail++;
            $display("FAIL b2b_hold: cursor=(%0d,%0d) piece=(%0d,%0d) dir=%b, required (5,3) (3,3) 01",
                     cursor_x, cursor_y, piece_x, piece_y, direction);
        end
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_cursor_bounds();
        test_legal_move();
        test_reject();
        test_cancel_timeout();
        test_reset_in_issue();
        test_simultaneous();
        test_back_to_back();
        repeat (5) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL pending_strobes: %0d expected strobes never seen, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
